// File: rtl/map_table_pkg.sv
// Shared rename types: tag widths, map entries
// and the CDB tag-match helper.
package rename_pkg;

  localparam int PR       = 6;
  localparam int AR       = 5;
  localparam int NUM_ARCH = 32;
  localparam int WAYS     = 3;

  typedef logic [PR-1:0] phys_tag_t;
  typedef logic [AR-1:0] arch_idx_t;

  typedef struct packed {
    phys_tag_t tag;
    logic      ready;
  } map_entry_t;

  function automatic logic cdb_hit(
    input phys_tag_t                  t,
    input logic      [WAYS-1:0]       v,
    input phys_tag_t [WAYS-1:0]       tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (v[k] && tags[k] == t) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/map_table_if.sv
// Rename-stage bundle between dispatch, the free
// list, the CDB and the map table.
interface map_table_if
  import rename_pkg::*;
();

  logic      [WAYS-1:0]     dispatch_en;
  arch_idx_t [WAYS-1:0]     dest_arch;
  arch_idx_t [WAYS-1:0]     src1_arch;
  arch_idx_t [WAYS-1:0]     src2_arch;
  phys_tag_t [WAYS-1:0]     free_reg;
  logic      [WAYS-1:0]     free_valid;
  logic      [WAYS-1:0]     cdb_valid;
  phys_tag_t [WAYS-1:0]     cdb_tag;
  logic                     recover_en;
  phys_tag_t [NUM_ARCH-1:0] arch_map;

  logic      [WAYS-1:0]     rename_valid;
  logic                     rename_stall;
  phys_tag_t [WAYS-1:0]     src1_tag;
  phys_tag_t [WAYS-1:0]     src2_tag;
  logic      [WAYS-1:0]     src1_ready;
  logic      [WAYS-1:0]     src2_ready;
  phys_tag_t [WAYS-1:0]     dest_tag;
  phys_tag_t [WAYS-1:0]     old_tag;

  modport master (
    output dispatch_en, dest_arch,
    output src1_arch, src2_arch,
    output free_reg, free_valid,
    output cdb_valid, cdb_tag,
    output recover_en, arch_map,
    input  rename_valid, rename_stall,
    input  src1_tag, src2_tag,
    input  src1_ready, src2_ready,
    input  dest_tag, old_tag
  );

  modport slave (
    input  dispatch_en, dest_arch,
    input  src1_arch, src2_arch,
    input  free_reg, free_valid,
    input  cdb_valid, cdb_tag,
    input  recover_en, arch_map,
    output rename_valid, rename_stall,
    output src1_tag, src2_tag,
    output src1_ready, src2_ready,
    output dest_tag, old_tag
  );

endinterface

// File: rtl/map_table_rename_group_fwd.sv
// Intra-group RAW/WAW forwarding; slot 2 is oldest,
// so the nearest higher-numbered writer wins.
module rename_group_fwd
  import rename_pkg::*;
(
  input  arch_idx_t  [WAYS-1:0] dest_arch_i,
  input  arch_idx_t  [WAYS-1:0] src1_arch_i,
  input  arch_idx_t  [WAYS-1:0] src2_arch_i,
  input  logic       [WAYS-1:0] rename_valid_i,
  input  phys_tag_t  [WAYS-1:0] free_reg_i,
  input  map_entry_t [WAYS-1:0] src1_raw_i,
  input  map_entry_t [WAYS-1:0] src2_raw_i,
  input  phys_tag_t  [WAYS-1:0] old_raw_i,
  output map_entry_t [WAYS-1:0] src1_o,
  output map_entry_t [WAYS-1:0] src2_o,
  output phys_tag_t  [WAYS-1:0] old_tag_o
);

  always_comb begin
    src1_o    = src1_raw_i;
    src2_o    = src2_raw_i;
    old_tag_o = old_raw_i;
    for (int w = 0; w < WAYS; w++) begin
      // Scan oldest to youngest; last hit is the nearest.
      for (int j = WAYS-1; j > w; j--) begin
        if (rename_valid_i[j] &&
            dest_arch_i[j] != '0) begin
          if (dest_arch_i[j] == src1_arch_i[w])
            src1_o[w] = '{free_reg_i[j], 1'b0};
          if (dest_arch_i[j] == src2_arch_i[w])
            src2_o[w] = '{free_reg_i[j], 1'b0};
          if (dest_arch_i[j] == dest_arch_i[w])
            old_tag_o[w] = free_reg_i[j];
        end
      end
    end
  end

endmodule

// File: rtl/map_table.sv
// Three-wide speculative register map table with
// CDB wakeup and architectural-map recovery.
module map_table
  import rename_pkg::*;
(
  input logic        clock,
  input logic        reset,
  map_table_if.slave mt
);

  map_entry_t [NUM_ARCH-1:0] tbl_q, tbl_d;

  logic       [WAYS-1:0] rv;
  map_entry_t [WAYS-1:0] s1_raw, s2_raw;
  map_entry_t [WAYS-1:0] s1_fin, s2_fin;
  phys_tag_t  [WAYS-1:0] old_raw, old_fin;

  assign rv = mt.dispatch_en & mt.free_valid &
              {WAYS{~mt.recover_en}};

  assign mt.rename_valid = rv;
  assign mt.rename_stall =
    |(mt.dispatch_en & ~mt.free_valid);

  always_comb begin
    s1_raw  = '0;
    s2_raw  = '0;
    old_raw = '0;
    for (int w = 0; w < WAYS; w++) begin
      s1_raw[w] = tbl_q[mt.src1_arch[w]];
      s2_raw[w] = tbl_q[mt.src2_arch[w]];
      s1_raw[w].ready = s1_raw[w].ready |
        cdb_hit(s1_raw[w].tag, mt.cdb_valid,
                mt.cdb_tag);
      s2_raw[w].ready = s2_raw[w].ready |
        cdb_hit(s2_raw[w].tag, mt.cdb_valid,
                mt.cdb_tag);
      old_raw[w] = tbl_q[mt.dest_arch[w]].tag;
    end
  end

  rename_group_fwd u_fwd (
    .dest_arch_i    (mt.dest_arch),
    .src1_arch_i    (mt.src1_arch),
    .src2_arch_i    (mt.src2_arch),
    .rename_valid_i (rv),
    .free_reg_i     (mt.free_reg),
    .src1_raw_i     (s1_raw),
    .src2_raw_i     (s2_raw),
    .old_raw_i      (old_raw),
    .src1_o         (s1_fin),
    .src2_o         (s2_fin),
    .old_tag_o      (old_fin)
  );

  always_comb begin
    mt.src1_tag   = '0;
    mt.src2_tag   = '0;
    mt.src1_ready = '0;
    mt.src2_ready = '0;
    mt.dest_tag   = '0;
    mt.old_tag    = '0;
    for (int w = 0; w < WAYS; w++) begin
      mt.src1_tag[w]   = s1_fin[w].tag;
      mt.src2_tag[w]   = s2_fin[w].tag;
      mt.src1_ready[w] = s1_fin[w].ready;
      mt.src2_ready[w] = s2_fin[w].ready;
      mt.old_tag[w]    = old_fin[w];
      if (rv[w]) mt.dest_tag[w] = mt.free_reg[w];
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if (mt.recover_en) begin
      for (int i = 1; i < NUM_ARCH; i++)
        tbl_d[i] = '{mt.arch_map[i], 1'b1};
    end else begin
      for (int i = 1; i < NUM_ARCH; i++) begin
        if (cdb_hit(tbl_q[i].tag, mt.cdb_valid,
                    mt.cdb_tag))
          tbl_d[i].ready = 1'b1;
      end
      // Oldest first so the youngest WAW writer wins.
      for (int w = WAYS-1; w >= 0; w--) begin
        if (rv[w] && mt.dest_arch[w] != '0)
          tbl_d[mt.dest_arch[w]] =
            '{mt.free_reg[w], 1'b0};
      end
    end
    tbl_d[0] = '{'0, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++)
        tbl_q[i] <= '{PR'(i), 1'b1};
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Directed and random checks of map_table against
// an array-based rename model.
module tb_map_table;
  import rename_pkg::*;

  logic clk;
  logic rst;

  map_table_if mif ();

  map_table dut (
    .clock (clk),
    .reset (rst),
    .mt    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int ref_tag [NUM_ARCH];
  bit ref_rdy [NUM_ARCH];

  function automatic void chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endfunction

  function automatic bit on_cdb(input int t);
    for (int k = 0; k < WAYS; k++)
      if (mif.cdb_valid[k] &&
          int'(mif.cdb_tag[k]) == t) return 1;
    return 0;
  endfunction

  function automatic bit exp_rv(input int w);
    return mif.dispatch_en[w] &&
           mif.free_valid[w] && !mif.recover_en;
  endfunction

  // Value of arch reg a as seen by slot w.
  function automatic void look(
    input  int w,
    input  int a,
    output int t,
    output bit r
  );
    t = ref_tag[a];
    r = ref_rdy[a] || on_cdb(t);
    if (a == 0) return;
    for (int j = w + 1; j < WAYS; j++) begin
      if (exp_rv(j) && int'(mif.dest_arch[j]) == a) begin
        t = int'(mif.free_reg[j]);
        r = 0;
        return;
      end
    end
  endfunction

  task automatic model_check();
    int t;
    bit r;
    bit stl;
    stl = 0;
    for (int w = 0; w < WAYS; w++) begin
      chk($sformatf("rename_valid[%0d]", w),
          32'(mif.rename_valid[w]), 32'(exp_rv(w)));
      if (mif.dispatch_en[w] && !mif.free_valid[w])
        stl = 1;
      chk($sformatf("dest_tag[%0d]", w),
          32'(mif.dest_tag[w]),
          exp_rv(w) ? 32'(mif.free_reg[w]) : 0);
      if (mif.dispatch_en[w] && !mif.free_valid[w])
        continue;
      look(w, int'(mif.src1_arch[w]), t, r);
      chk($sformatf("src1_tag[%0d]", w),
          32'(mif.src1_tag[w]), 32'(t));
      chk($sformatf("src1_ready[%0d]", w),
          32'(mif.src1_ready[w]), 32'(r));
      look(w, int'(mif.src2_arch[w]), t, r);
      chk($sformatf("src2_tag[%0d]", w),
          32'(mif.src2_tag[w]), 32'(t));
      chk($sformatf("src2_ready[%0d]", w),
          32'(mif.src2_ready[w]), 32'(r));
      look(w, int'(mif.dest_arch[w]), t, r);
      chk($sformatf("old_tag[%0d]", w),
          32'(mif.old_tag[w]), 32'(t));
    end
    chk("rename_stall", 32'(mif.rename_stall),
        32'(stl));
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        ref_tag[i] = i;
        ref_rdy[i] = 1;
      end
    end else if (mif.recover_en) begin
      for (int i = 1; i < NUM_ARCH; i++) begin
        ref_tag[i] = int'(mif.arch_map[i]);
        ref_rdy[i] = 1;
      end
    end else begin
      for (int i = 1; i < NUM_ARCH; i++)
        if (on_cdb(ref_tag[i])) ref_rdy[i] = 1;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (exp_rv(w) && mif.dest_arch[w] != 0) begin
          ref_tag[mif.dest_arch[w]] =
            int'(mif.free_reg[w]);
          ref_rdy[mif.dest_arch[w]] = 0;
        end
      end
    end
  endtask

  task automatic settle(input bit do_chk);
    #1;
    if (do_chk) model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    mif.dispatch_en = '0;
    mif.dest_arch   = '0;
    mif.src1_arch   = '0;
    mif.src2_arch   = '0;
    mif.free_reg    = '0;
    mif.free_valid  = '0;
    mif.cdb_valid   = '0;
    mif.cdb_tag     = '0;
    mif.recover_en  = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      ref_tag[i] = 0;
      ref_rdy[i] = 0;
    end
    idle();
    mif.arch_map = '0;
    rst = 1'b1;
    @(negedge clk);
    settle(0);
    edge_step();
    settle(1);
    edge_step();
    rst = 1'b0;

    // idle lookup after reset
    mif.src1_arch[0] = 5'd5;
    settle(1);
    chk("reset_src1_tag", 32'(mif.src1_tag[0]), 5);
    chk("reset_src1_rdy", 32'(mif.src1_ready[0]), 1);
    chk("reset_dest_tag", 32'(mif.dest_tag), 0);
    chk("reset_rv", 32'(mif.rename_valid), 0);
    chk("reset_stall", 32'(mif.rename_stall), 0);
    edge_step();

    // single rename
    idle();
    mif.dispatch_en  = 3'b100;
    mif.free_valid   = 3'b100;
    mif.dest_arch[2] = 5'd3;
    mif.free_reg[2]  = 6'd40;
    settle(1);
    chk("single_old", 32'(mif.old_tag[2]), 3);
    chk("single_dest", 32'(mif.dest_tag[2]), 40);
    edge_step();
    idle();
    mif.src1_arch[0] = 5'd3;
    settle(1);
    chk("single_x3_tag", 32'(mif.src1_tag[0]), 40);
    chk("single_x3_rdy", 32'(mif.src1_ready[0]), 0);
    edge_step();
    mif.cdb_valid  = 3'b010;
    mif.cdb_tag[1] = 6'd40;
    settle(1);
    chk("cdb_bypass_rdy", 32'(mif.src1_ready[0]), 1);
    edge_step();
    idle();
    mif.src1_arch[0] = 5'd3;
    settle(1);
    chk("cdb_table_rdy", 32'(mif.src1_ready[0]), 1);
    edge_step();

    // group RAW/WAW
    idle();
    mif.dispatch_en  = 3'b111;
    mif.free_valid   = 3'b111;
    mif.dest_arch[2] = 5'd7;
    mif.free_reg[2]  = 6'd33;
    mif.dest_arch[1] = 5'd7;
    mif.free_reg[1]  = 6'd34;
    mif.src1_arch[1] = 5'd7;
    mif.dest_arch[0] = 5'd9;
    mif.free_reg[0]  = 6'd35;
    mif.src2_arch[0] = 5'd7;
    settle(1);
    chk("grp_s1_tag", 32'(mif.src1_tag[1]), 33);
    chk("grp_s1_rdy", 32'(mif.src1_ready[1]), 0);
    chk("grp_s1_old", 32'(mif.old_tag[1]), 33);
    chk("grp_s0_src2", 32'(mif.src2_tag[0]), 34);
    edge_step();
    idle();
    mif.src1_arch[2] = 5'd7;
    settle(1);
    chk("grp_x7_tag", 32'(mif.src1_tag[2]), 34);
    edge_step();

    // CDB collision with rename
    idle();
    mif.dispatch_en  = 3'b100;
    mif.free_valid   = 3'b100;
    mif.dest_arch[2] = 5'd4;
    mif.free_reg[2]  = 6'd41;
    settle(1);
    edge_step();
    mif.free_reg[2] = 6'd42;
    mif.cdb_valid   = 3'b001;
    mif.cdb_tag[0]  = 6'd41;
    settle(1);
    edge_step();
    idle();
    mif.src1_arch[0] = 5'd4;
    settle(1);
    chk("coll_x4_tag", 32'(mif.src1_tag[0]), 42);
    chk("coll_x4_rdy", 32'(mif.src1_ready[0]), 0);
    edge_step();

    // recovery with simultaneous dispatch
    for (int i = 0; i < NUM_ARCH; i++)
      mif.arch_map[i] = (i == 0) ? 6'd0 : PR'(i + 1);
    mif.recover_en   = 1'b1;
    mif.dispatch_en  = 3'b111;
    mif.free_valid   = 3'b111;
    mif.dest_arch[2] = 5'd6;
    mif.free_reg[2]  = 6'd50;
    mif.dest_arch[1] = 5'd8;
    mif.free_reg[1]  = 6'd51;
    mif.dest_arch[0] = 5'd2;
    mif.free_reg[0]  = 6'd52;
    settle(1);
    chk("recov_rv", 32'(mif.rename_valid), 0);
    edge_step();
    idle();
    mif.src1_arch[0] = 5'd6;
    mif.src2_arch[0] = 5'd0;
    settle(1);
    chk("recov_x6_tag", 32'(mif.src1_tag[0]), 7);
    chk("recov_x6_rdy", 32'(mif.src1_ready[0]), 1);
    chk("recov_x0_tag", 32'(mif.src2_tag[0]), 0);
    chk("recov_x0_rdy", 32'(mif.src2_ready[0]), 1);
    edge_step();

    // stall: only slot 2 renames
    idle();
    mif.dispatch_en  = 3'b111;
    mif.free_valid   = 3'b100;
    mif.dest_arch[2] = 5'd10;
    mif.free_reg[2]  = 6'd53;
    mif.dest_arch[1] = 5'd11;
    mif.dest_arch[0] = 5'd12;
    settle(1);
    chk("stall_flag", 32'(mif.rename_stall), 1);
    chk("stall_rv", 32'(mif.rename_valid), 3'b100);
    edge_step();
    idle();
    mif.src1_arch[0] = 5'd10;
    mif.src2_arch[0] = 5'd11;
    settle(1);
    chk("stall_x10", 32'(mif.src1_tag[0]), 53);
    chk("stall_x11", 32'(mif.src2_tag[0]), 12);
    edge_step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      mif.dispatch_en = 3'($urandom_range(0, 7));
      mif.free_valid  = ($urandom_range(0, 3) == 0) ?
        3'($urandom_range(0, 7)) : 3'b111;
      for (int w = 0; w < WAYS; w++) begin
        mif.dest_arch[w] = mif.dispatch_en[w] ?
          5'($urandom_range(1, 31)) :
          5'($urandom_range(0, 31));
        mif.src1_arch[w] = 5'($urandom_range(0, 31));
        mif.src2_arch[w] = 5'($urandom_range(0, 31));
        mif.free_reg[w]  = 6'($urandom_range(0, 63));
        mif.cdb_tag[w]   = 6'($urandom_range(0, 63));
      end
      mif.cdb_valid  = 3'($urandom_range(0, 7));
      mif.recover_en = ($urandom_range(0, 19) == 0);
      if (mif.recover_en)
        for (int i = 0; i < NUM_ARCH; i++)
          mif.arch_map[i] = 6'($urandom_range(0, 63));
      settle(1);
      edge_step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/map_table.md
# map_table

Three-wide speculative register map table for the rename stage. It sits directly downstream of the free list: it consumes the up-to-three free physical tags the free list hands out each cycle and binds them to destination architectural registers. It produces source tags with ready bits for the reservation stations, and the previous (old) destination tag for the ROB, which later returns to the free list at retire. It tracks completion through CDB broadcasts and restores from the architectural map on branch-mispredict recovery.

## Interface
- `PR`, 6: physical tag width (64 physical registers).
- `AR`, 5: architectural index width (32 registers).
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `dispatch_en`  in  3: per-slot rename request; slot 2 is oldest in program order.
- `dest_arch`, `src1_arch`, `src2_arch`  in  3×AR: per-slot architectural indices.
- `free_reg`  in  3×PR: free tags from the free list, slot-aligned.
- `free_valid`  in  3: per-slot free-tag validity.
- `cdb_valid`  in  3: completion broadcast valid.
- `cdb_tag`  in  3×PR: completing physical tags.
- `recover_en`  in  1: mispredict recovery.
- `arch_map`  in  32×PR: committed architectural map.
- `rename_valid`  out  3: `dispatch_en & free_valid`.
- `rename_stall`  out  1: `|(dispatch_en & ~free_valid)`.
- `src1_tag`, `src2_tag`  out  3×PR: renamed sources.
- `src1_ready`, `src2_ready`  out  3: source operand available.
- `dest_tag`  out  3×PR: new tag (= `free_reg` when renamed, else 0).
- `old_tag`  out  3×PR: prior mapping of `dest_arch`, for the ROB.

## Operation
- **State:** 32 entries of {tag, ready}, stored in flops.
- **Entry 0 (x0):** constant {0, 1}. Writes to index 0 are ignored. Dispatch must not request a tag for x0 destinations. A slot with `dest_arch` = 0 yields `old_tag` 0.
- **Source lookup (combinational):** read table entry, then apply intra-group forwarding.
  - If an older valid slot in the same group writes the same non-zero index, use the youngest such older slot's `free_reg`, with ready = 0.
  - Otherwise, if the table tag matches any valid `cdb_tag` this cycle, ready = 1 (CDB bypass).
- **Old tag:** same forwarding rule. For a WAW within the group, the younger slot's `old_tag` is the older slot's new tag.
- **Table update on the next edge, per renamed slot:** `entry[dest_arch]` ← {`free_reg`, 0}. Under WAW the youngest slot wins (write order slot 2, 1, 0).
- **CDB:** every entry whose tag equals a valid `cdb_tag` gets ready ← 1.
  - A rename write to the same entry in the same cycle overrides the CDB set: the new tag is not ready.
- **Non-renamed slots** (`dispatch_en` = 1, `free_valid` = 0): no write. The slot's outputs are don't-care, except `dest_tag` = 0.
- **Recovery:** `recover_en` loads `entry[i]` ← {`arch_map[i]`, 1} for all i. Rename writes and CDB updates in that cycle are discarded. `rename_valid` is forced to 0.
- **Priority:** reset > recover_en > (rename writes over CDB per entry).

## Timing
- Rename is zero-latency: all outputs are combinational from registered state and the current inputs.
- Table writes are visible the cycle after dispatch.
- **Reset value:**
  - `entry[i]` = {i, 1}, consistent with the free list resetting to hold tags 32–63.
  - With idle inputs after reset: `src*_tag` = `src*_arch`, `src*_ready` = 1, `dest_tag` = 0, `rename_valid` = 0, `rename_stall` = 0.
- **Reset or recovery mid-group:** the whole group is dropped. No partial writes.
- **Same-cycle CDB on a tag just read:** reported ready in that cycle (bypass). It is also ready in the table from the next cycle.
- **No handshake beyond `rename_valid`:** the free list advances by its own `FreeRegValid`. Dispatch must align `dispatch_en` with `free_valid`.

## Structure
- **Shared package `rename_pkg`:**
  - `PR`, `AR`, `NUM_ARCH` = 32, `WAYS` = 3.
  - `typedef phys_tag_t` (`logic [PR-1:0]`).
  - `typedef struct packed {phys_tag_t tag; logic ready;} map_entry_t`.
- **One sub-module, `rename_group_fwd`:** combinational intra-group RAW/WAW forwarding. Inputs: per-slot arch indices, `rename_valid`, `free_reg`, and raw table reads. Outputs: final source tags/ready bits and old tags.
- The top level holds the table, CDB matching, and recovery.

## Test plan
- **Reset, then idle lookup:** src1 = 5 in slot 0 → `src1_tag` = 5, ready = 1.
- **Single rename:** slot 2, dest 3, `free_reg[2]` = 40 → `old_tag` = 3, `dest_tag` = 40. Next cycle, lookup of x3 → tag 40, ready = 0. Then CDB tag 40 → the following cycle lookup is ready = 1.
- **Group RAW/WAW:** slot 2 dest 7 ← 33; slot 1 dest 7 ← 34 with src1 = 7; slot 0 src2 = 7.
  - Slot 1: `src1_tag` = 33, not ready; `old_tag` = 33.
  - Slot 0: `src2_tag` = 34.
  - Table x7 = 34 next cycle.
- **CDB collision:** entry x4 = 41, not ready; same cycle, CDB 41 plus rename dest 4 ← 42 → next cycle x4 = {42, 0}.
- **Recovery:** after renames, `recover_en` with `arch_map[i]` = i+1 (x0 excluded) and a simultaneous dispatch → `rename_valid` = 0; next cycle x6 = {7, 1}, x0 = {0, 1}.
- **Stall:** `dispatch_en` = 3'b111, `free_valid` = 3'b100 → `rename_stall` = 1; only slot 2 is written.
